// File: rtl/flmux_pipe.sv
// Pipelined channel multiplexer: stage 0 picks one of NIN channels, then DEPTH-1 plain delay stages.
// Optional occupancy counter output CNT is enabled by defining FLMUX_PIPE_OCCUPANCY_EN.
module flmux_pipe #(
  parameter int WIDTH = 8,
  parameter int NIN   = 4,
  parameter int DEPTH = 3,
  parameter int SELW  = $clog2(NIN)
) (
  input  logic                   CK,
  input  logic                   CD,
  input  logic                   SP,
  input  logic [SELW-1:0]        SD,
  input  logic [NIN*WIDTH-1:0]   D,
  input  logic                   DV,
  output logic [WIDTH-1:0]       Q,
  output logic                   QV,
  output logic                   FULL
`ifdef FLMUX_PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] CNT
`endif
);

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [WIDTH-1:0] s0_d;
  logic             v0_d;

  // An out-of-range select matches no channel, so stage 0 loads zero data and an invalid flag.
  always_comb begin
    s0_d = '0;
    v0_d = 1'b0;
    for (int k = 0; k < NIN; k++) begin
      if (SD == SELW'(k)) begin
        s0_d = D[k*WIDTH +: WIDTH];
        v0_d = DV;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (CD) begin
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= '0;
      end
      v_q <= '0;
    end else if (SP) begin
      s_q[0] <= s0_d;
      v_q[0] <= v0_d;
      for (int i = 1; i < DEPTH; i++) begin
        s_q[i] <= s_q[i-1];
        v_q[i] <= v_q[i-1];
      end
    end
  end

  assign Q    = s_q[DEPTH-1];
  assign QV   = v_q[DEPTH-1];
  assign FULL = &v_q;

`ifdef FLMUX_PIPE_OCCUPANCY_EN
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // One flag enters and the last one leaves on every enabled edge, so the count stays within 0..DEPTH.
  always_comb begin
    cnt_d = cnt_q + CW'(v0_d) - CW'(v_q[DEPTH-1]);
  end

  always_ff @(posedge CK) begin
    if (CD) begin
      cnt_q <= '0;
    end else if (SP) begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT = cnt_q;
`endif

endmodule

// File: tb/tb_flmux_pipe.sv
// Bench for flmux_pipe: three instances (default, 3-bit select, single stage) against a queue model,
// plus directed literal expectations for each scenario.
module tb_flmux_pipe;

  logic        ck;
  logic        cd;
  logic        sp;
  logic [2:0]  sd3;
  logic [31:0] d;
  logic        dv;

  logic [7:0] q0, q1, q2;
  logic       qv0, qv1, qv2;
  logic       full0, full1, full2;
`ifdef FLMUX_PIPE_OCCUPANCY_EN
  logic [1:0] cnt0, cnt1;
  logic [0:0] cnt2;
`endif

  int checks = 0;
  int errors = 0;
  bit started = 0;

  logic [8:0] m0[$];
  logic [8:0] m1[$];
  logic [8:0] m2[$];

  flmux_pipe #(.WIDTH(8), .NIN(4), .DEPTH(3)) u0 (
    .CK(ck), .CD(cd), .SP(sp), .SD(sd3[1:0]), .D(d), .DV(dv),
    .Q(q0), .QV(qv0), .FULL(full0)
`ifdef FLMUX_PIPE_OCCUPANCY_EN
    , .CNT(cnt0)
`endif
  );

  flmux_pipe #(.WIDTH(8), .NIN(4), .DEPTH(3), .SELW(3)) u1 (
    .CK(ck), .CD(cd), .SP(sp), .SD(sd3), .D(d), .DV(dv),
    .Q(q1), .QV(qv1), .FULL(full1)
`ifdef FLMUX_PIPE_OCCUPANCY_EN
    , .CNT(cnt1)
`endif
  );

  flmux_pipe #(.WIDTH(8), .NIN(4), .DEPTH(1)) u2 (
    .CK(ck), .CD(cd), .SP(sp), .SD(sd3[1:0]), .D(d), .DV(dv),
    .Q(q2), .QV(qv2), .FULL(full2)
`ifdef FLMUX_PIPE_OCCUPANCY_EN
    , .CNT(cnt2)
`endif
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each instance is a queue of {valid,data} entries, newest at the front, oldest at the back.
  function automatic logic [8:0] ent(input int sel, input logic v, input logic [31:0] dd);
    if (sel < 4) return {v, dd[sel*8 +: 8]};
    return 9'h0;
  endfunction

  function automatic int vcnt(input logic [8:0] qq[$]);
    int n = 0;
    foreach (qq[i]) if (qq[i][8]) n++;
    return n;
  endfunction

  always @(posedge ck) begin
    if (cd) begin
      m0 = {}; m1 = {}; m2 = {};
      for (int i = 0; i < 3; i++) begin
        m0.push_back(9'h0);
        m1.push_back(9'h0);
      end
      m2.push_back(9'h0);
      started = 1;
    end else if (sp && started) begin
      m0.push_front(ent(int'(sd3[1:0]), dv, d)); void'(m0.pop_back());
      m1.push_front(ent(int'(sd3), dv, d));      void'(m1.pop_back());
      m2.push_front(ent(int'(sd3[1:0]), dv, d)); void'(m2.pop_back());
    end
  end

  always @(negedge ck) begin
    logic [8:0] e0, e1, e2;
    if (started) begin
      e0 = m0[$]; e1 = m1[$]; e2 = m2[$];
      cmp("u0.Q", {24'h0, q0}, {24'h0, e0[7:0]});
      cmp("u0.QV", {31'h0, qv0}, {31'h0, e0[8]});
      cmp("u0.FULL", {31'h0, full0}, (vcnt(m0) == 3) ? 32'd1 : 32'd0);
      cmp("u1.Q", {24'h0, q1}, {24'h0, e1[7:0]});
      cmp("u1.QV", {31'h0, qv1}, {31'h0, e1[8]});
      cmp("u1.FULL", {31'h0, full1}, (vcnt(m1) == 3) ? 32'd1 : 32'd0);
      cmp("u2.Q", {24'h0, q2}, {24'h0, e2[7:0]});
      cmp("u2.QV", {31'h0, qv2}, {31'h0, e2[8]});
      cmp("u2.FULL", {31'h0, full2}, (vcnt(m2) == 1) ? 32'd1 : 32'd0);
`ifdef FLMUX_PIPE_OCCUPANCY_EN
      cmp("u0.CNT", {30'h0, cnt0}, vcnt(m0));
      cmp("u1.CNT", {30'h0, cnt1}, vcnt(m1));
      cmp("u2.CNT", {31'h0, cnt2}, vcnt(m2));
`endif
    end
  end

  task automatic step(input logic c, input logic s, input logic [2:0] sel, input logic v,
                      input logic [31:0] data);
    cd = c; sp = s; sd3 = sel; dv = v; d = data;
    @(posedge ck);
    @(negedge ck);
  endtask

  initial begin
    cd = 1'b1; sp = 1'b0; sd3 = 3'd0; dv = 1'b0; d = 32'h0;

    // Reset state
    step(1, 0, 0, 0, 32'h0);
    cmp("rst.Q", {24'h0, q0}, 32'h0);
    cmp("rst.QV", {31'h0, qv0}, 32'h0);
    cmp("rst.FULL", {31'h0, full0}, 32'h0);

    // Single sample on channel 2 reaches the output after the third edge
    step(0, 1, 2, 1, 32'h00A5_0000);
    cmp("lat.QV1", {31'h0, qv0}, 32'h0);
    cmp("lat.d1.Q", {24'h0, q2}, 32'hA5);
    step(0, 1, 0, 0, 32'h0);
    cmp("lat.QV2", {31'h0, qv0}, 32'h0);
    step(0, 1, 0, 0, 32'h0);
    cmp("lat.Q3", {24'h0, q0}, 32'hA5);
    cmp("lat.QV3", {31'h0, qv0}, 32'h1);

    // Stream channels 0..3
    step(1, 0, 0, 0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 3'(k), 1, 32'h1312_1110);
      if (k == 2) begin
        cmp("strm.FULL", {31'h0, full0}, 32'h1);
        cmp("strm.Q0", {24'h0, q0}, 32'h10);
`ifdef FLMUX_PIPE_OCCUPANCY_EN
        cmp("strm.CNT", {30'h0, cnt0}, 32'd3);
`endif
      end
    end
    cmp("strm.Q1", {24'h0, q0}, 32'h11);
    step(0, 1, 0, 0, 32'h0);
    cmp("strm.Q2", {24'h0, q0}, 32'h12);
    step(0, 1, 0, 0, 32'h0);
    cmp("strm.Q3", {24'h0, q0}, 32'h13);
    cmp("strm.FULLoff", {31'h0, full0}, 32'h0);

    // Hold with SP=0 while inputs toggle
    step(1, 0, 0, 0, 32'h0);
    step(0, 1, 1, 1, 32'h0000_5C00);
    step(0, 1, 0, 0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 3'(k), k[0], $urandom);
      cmp("hold.QV", {31'h0, qv0}, 32'h0);
      cmp("hold.Q", {24'h0, q0}, 32'h0);
    end
    step(0, 1, 0, 0, 32'h0);
    cmp("hold.exitQ", {24'h0, q0}, 32'h5C);
    cmp("hold.exitQV", {31'h0, qv0}, 32'h1);

    // Out-of-range select leaves an empty slot between two valid samples
    step(1, 0, 0, 0, 32'h0);
    step(0, 1, 1, 1, 32'h0000_7700);
    step(0, 1, 5, 1, 32'h0000_FF00);
    step(0, 1, 2, 1, 32'h0066_0000);
    cmp("oor.Q0", {24'h0, q1}, 32'h77);
    cmp("oor.QV0", {31'h0, qv1}, 32'h1);
    step(0, 1, 0, 0, 32'h0);
    cmp("oor.Q1", {24'h0, q1}, 32'h0);
    cmp("oor.QV1", {31'h0, qv1}, 32'h0);
    step(0, 1, 0, 0, 32'h0);
    cmp("oor.Q2", {24'h0, q1}, 32'h66);
    cmp("oor.QV2", {31'h0, qv1}, 32'h1);

    // Reset while full, then the first sample sees full latency
    step(1, 0, 0, 0, 32'h0);
    for (int k = 0; k < 3; k++) step(0, 1, 3'(k), 1, 32'h0033_2211);
    cmp("fr.FULL", {31'h0, full0}, 32'h1);
    step(1, 1, 1, 1, 32'hFFFF_FFFF);
    cmp("fr.Q", {24'h0, q0}, 32'h0);
    cmp("fr.QV", {31'h0, qv0}, 32'h0);
    cmp("fr.FULL0", {31'h0, full0}, 32'h0);
`ifdef FLMUX_PIPE_OCCUPANCY_EN
    cmp("fr.CNT", {30'h0, cnt0}, 32'd0);
`endif
    step(0, 1, 3, 1, 32'h4400_0000);
    step(0, 1, 0, 0, 32'h0);
    cmp("fr.QV2", {31'h0, qv0}, 32'h0);
    step(0, 1, 0, 0, 32'h0);
    cmp("fr.Q3", {24'h0, q0}, 32'h44);

    // Single-stage instance follows DV pattern 1,0,1
    step(1, 0, 0, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, (k != 1), 32'h0000_0021);
      cmp("d1.QV", {31'h0, qv2}, (k != 1) ? 32'h1 : 32'h0);
      cmp("d1.FULL", {31'h0, full2}, (k != 1) ? 32'h1 : 32'h0);
`ifdef FLMUX_PIPE_OCCUPANCY_EN
      cmp("d1.CNT", {31'h0, cnt2}, (k != 1) ? 32'h1 : 32'h0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
